// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch stage.
// Contents: data widths, the invalid ROB tag, the op-number layout,
// the instruction-queue entry record and the RV32I decoder used on the
// queue head.
//
// Op-number layout (OPNUM_W = 8 bits): {op_class(4), funct3(3), alt(1)}.
// alt is instr[30] for R-type ops and for the I-type shift-right group.
// Classes without a funct3 field carry funct3 = 0. OPNUM_NULL (all zero)
// marks an undecodable word. The queue drops such a word without dispatching it.
package dispatch_queue_pkg;

  localparam int INST_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int OPNUM_W     = 8;
  localparam int INVALID_ROB = 0;

  typedef enum logic [3:0] {
    CLS_NULL, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP
  } op_class_e;

  localparam logic [OPNUM_W-1:0] OPNUM_NULL = '0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              pred_jump;
    logic [ADDR_W-1:0] rollback_pc;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  typedef struct packed {
    logic [OPNUM_W-1:0] opnum;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [DATA_W-1:0]  imm;
    logic               is_ls;
    logic               is_jump;
    logic               is_store;
  } decoded_t;

  // Unused source fields are forced to x0. The register file then reports
  // them as ready without any rename tag.
  function automatic decoded_t decode(input logic [INST_W-1:0] inst);
    decoded_t  d;
    op_class_e cls;
    logic [2:0] f3;
    logic       alt;
    logic       ok;
    d     = '0;
    cls   = CLS_NULL;
    f3    = inst[14:12];
    alt   = 1'b0;
    ok    = 1'b1;
    d.rd  = inst[11:7];
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin
        cls   = (inst[5]) ? CLS_LUI : CLS_AUIPC;
        f3    = 3'b000;
        d.imm = {inst[31:12], 12'b0};
        d.rs1 = 5'd0;
        d.rs2 = 5'd0;
      end
      7'b1101111: begin
        cls       = CLS_JAL;
        f3        = 3'b000;
        d.imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        d.rs1     = 5'd0;
        d.rs2     = 5'd0;
        d.is_jump = 1'b1;
      end
      7'b1100111: begin
        cls       = CLS_JALR;
        ok        = (f3 == 3'b000);
        d.imm     = {{20{inst[31]}}, inst[31:20]};
        d.rs2     = 5'd0;
        d.is_jump = 1'b1;
      end
      7'b1100011: begin
        cls       = CLS_BRANCH;
        ok        = (f3[2:1] != 2'b01);
        d.imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        d.rd      = 5'd0;
        d.is_jump = 1'b1;
      end
      7'b0000011: begin
        cls     = CLS_LOAD;
        ok      = (f3 != 3'd3) && (f3[2:1] != 2'b11);
        d.imm   = {{20{inst[31]}}, inst[31:20]};
        d.rs2   = 5'd0;
        d.is_ls = 1'b1;
      end
      7'b0100011: begin
        cls        = CLS_STORE;
        ok         = (f3 < 3'd3);
        d.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d.rd       = 5'd0;
        d.is_ls    = 1'b1;
        d.is_store = 1'b1;
      end
      7'b0010011: begin
        cls   = CLS_OPIMM;
        alt   = (f3 == 3'b101) & inst[30];
        d.imm = {{20{inst[31]}}, inst[31:20]};
        d.rs2 = 5'd0;
      end
      7'b0110011: begin
        cls = CLS_OP;
        alt = inst[30];
      end
      default: ok = 1'b0;
    endcase
    if (ok) d.opnum = {cls, f3, alt};
    else    d = '0;
    return d;
  endfunction

endpackage

// File: rtl/dispatch_queue_inst_queue.sv
// inst_queue: circular FIFO with a synchronous flush.
// Ports: clk/rst_n (async active-low); flush empties the queue; push writes
// wdata at the tail; pop advances the head. rdata always shows the head
// entry. count gives the occupancy (0..DEPTH).
// The caller must push only when count < DEPTH and pop only when count != 0.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module inst_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = IQ_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign rdata = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= tail + PTR_ONE;
      end
      if (pop) head <= head + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: buffered decode/dispatch stage between the fetcher and
// the ROB, reservation station (RS) and load/store buffer (LSB).
// Ports: clk, rst_n (async active-low), rdy (global enable).
//   Fetch side:    fch_valid/inst/pc/pred_jump/rollback_pc in, fch_ready out.
//   rollback:      flushes the queue.
//   Register file: rs1/rs2_to_reg out; Q/V_from_reg in; reg_en/rd/rob_id out.
//   ROB:           Q_to_rob out; Q_ready/V_from_rob in; rob_id_from_rob in;
//                  rob_en and rob_* payload out.
//   CDB:           cdb_valid/rob_id/data in. Channel 0 has the highest priority.
//   RS/LSB:        rs_en/ls_en plus the shared disp_* payload.
// The queue issues the head instruction combinationally in the cycle it
// fires, and pops it on the same edge.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int IQ_DEPTH = 8,
  parameter int NUM_CDB  = 2,
  parameter int ROB_ID_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rdy,
  input  logic                         fch_valid,
  input  logic [INST_W-1:0]            fch_inst,
  input  logic [ADDR_W-1:0]            fch_pc,
  input  logic                         fch_pred_jump,
  input  logic [ADDR_W-1:0]            fch_rollback_pc,
  output logic                         fch_ready,
  input  logic                         rollback,
  output logic [4:0]                   rs1_to_reg,
  output logic [4:0]                   rs2_to_reg,
  input  logic [ROB_ID_W-1:0]          Q1_from_reg,
  input  logic [ROB_ID_W-1:0]          Q2_from_reg,
  input  logic [DATA_W-1:0]            V1_from_reg,
  input  logic [DATA_W-1:0]            V2_from_reg,
  output logic [ROB_ID_W-1:0]          Q1_to_rob,
  output logic [ROB_ID_W-1:0]          Q2_to_rob,
  input  logic                         Q1_ready_from_rob,
  input  logic                         Q2_ready_from_rob,
  input  logic [DATA_W-1:0]            V1_from_rob,
  input  logic [DATA_W-1:0]            V2_from_rob,
  input  logic                         rob_full,
  input  logic                         rs_full,
  input  logic                         lsb_full,
  input  logic [ROB_ID_W-1:0]          rob_id_from_rob,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         rob_en,
  output logic                         reg_en,
  output logic                         rs_en,
  output logic                         ls_en,
  output logic [4:0]                   rob_rd,
  output logic [4:0]                   reg_rd,
  output logic                         rob_is_jump,
  output logic                         rob_is_store,
  output logic                         rob_pred_jump,
  output logic [ADDR_W-1:0]            rob_pc,
  output logic [ADDR_W-1:0]            rob_rollback_pc,
  output logic [ROB_ID_W-1:0]          reg_rob_id,
  output logic [ROB_ID_W-1:0]          disp_rob_id,
  output logic [OPNUM_W-1:0]           disp_opnum,
  output logic [DATA_W-1:0]            disp_V1,
  output logic [DATA_W-1:0]            disp_V2,
  output logic [ADDR_W-1:0]            disp_pc,
  output logic [DATA_W-1:0]            disp_imm,
  output logic [ROB_ID_W-1:0]          disp_Q1,
  output logic [ROB_ID_W-1:0]          disp_Q2
);

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;
  localparam logic [ROB_ID_W-1:0] INVALID_TAG = ROB_ID_W'(INVALID_ROB);

  iq_entry_t           push_entry;
  iq_entry_t           head_entry;
  logic [CNT_W-1:0]    count;
  decoded_t            dec;
  logic                head_live;
  logic                head_null;
  logic                target_free;
  logic                fire;
  logic                pop;
  logic                push;
  logic                flush;
  logic [NUM_CDB-1:0]  hit1;
  logic [NUM_CDB-1:0]  hit2;

  assign push_entry = '{inst: fch_inst, pc: fch_pc, pred_jump: fch_pred_jump,
                        rollback_pc: fch_rollback_pc};

  // rst_n appears here because count already reads 0 while reset is held.
  assign fch_ready = rst_n & !rollback & (count < CNT_W'(IQ_DEPTH));
  assign push      = fch_valid & fch_ready & rdy;
  assign flush     = rollback & rdy;

  assign dec         = decode(head_entry.inst);
  assign head_live   = rdy & (count != '0) & !rollback;
  assign head_null   = (dec.opnum == OPNUM_NULL);
  assign target_free = !rob_full & (dec.is_ls ? !lsb_full : !rs_full);
  assign fire        = head_live & target_free & !head_null;
  assign pop         = head_live & (target_free | head_null);

  inst_queue #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (IQ_ENTRY_W)
  ) u_inst_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (count)
  );

  // A CDB tag match is ignored for tag 0, because tag 0 means "already ready".
  genvar g;
  generate
    for (g = 0; g < NUM_CDB; g = g + 1) begin : g_cdb_match
      assign hit1[g] = cdb_valid[g] && (Q1_from_reg != INVALID_TAG)
                       && (Q1_from_reg == cdb_rob_id[g*ROB_ID_W +: ROB_ID_W]);
      assign hit2[g] = cdb_valid[g] && (Q2_from_reg != INVALID_TAG)
                       && (Q2_from_reg == cdb_rob_id[g*ROB_ID_W +: ROB_ID_W]);
    end
  endgenerate

  // Operand priority: CDB (lowest channel wins), then ROB, then register file.
  // The channel loop runs from high to low index so the lowest hit is assigned last.
  always_comb begin
    disp_Q1 = Q1_from_reg;
    disp_V1 = V1_from_reg;
    disp_Q2 = Q2_from_reg;
    disp_V2 = V2_from_reg;
    if (Q1_ready_from_rob) begin
      disp_Q1 = INVALID_TAG;
      disp_V1 = V1_from_rob;
    end
    if (Q2_ready_from_rob) begin
      disp_Q2 = INVALID_TAG;
      disp_V2 = V2_from_rob;
    end
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        disp_Q1 = INVALID_TAG;
        disp_V1 = cdb_data[i*DATA_W +: DATA_W];
      end
      if (hit2[i]) begin
        disp_Q2 = INVALID_TAG;
        disp_V2 = cdb_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rs1_to_reg      = dec.rs1;
  assign rs2_to_reg      = dec.rs2;
  assign Q1_to_rob       = Q1_from_reg;
  assign Q2_to_rob       = Q2_from_reg;

  assign rob_en          = fire;
  assign reg_en          = fire;
  assign rs_en           = fire & !dec.is_ls;
  assign ls_en           = fire & dec.is_ls;

  assign rob_rd          = dec.rd;
  assign reg_rd          = dec.rd;
  assign rob_is_jump     = dec.is_jump;
  assign rob_is_store    = dec.is_store;
  assign rob_pred_jump   = head_entry.pred_jump;
  assign rob_pc          = head_entry.pc;
  assign rob_rollback_pc = head_entry.rollback_pc;
  assign reg_rob_id      = rob_id_from_rob;
  assign disp_rob_id     = rob_id_from_rob;
  assign disp_opnum      = dec.opnum;
  assign disp_pc         = head_entry.pc;
  assign disp_imm        = dec.imm;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: a table of single-instruction
// vectors, hand sequences for the multi-cycle corners, and a randomized
// run checked against a queue-based reference model.
module tb_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int NCDB  = 2;
  localparam int RW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy, fch_valid, fch_pred_jump, fch_ready, rollback;
  logic [31:0] fch_inst, fch_pc, fch_rollback_pc;
  logic [4:0]  rs1_to_reg, rs2_to_reg, rob_rd, reg_rd;
  logic [RW-1:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob, rob_id_from_rob;
  logic [RW-1:0] reg_rob_id, disp_rob_id, disp_Q1, disp_Q2;
  logic [31:0] V1_from_reg, V2_from_reg, V1_from_rob, V2_from_rob;
  logic Q1_ready_from_rob, Q2_ready_from_rob, rob_full, rs_full, lsb_full;
  logic [NCDB-1:0]    cdb_valid;
  logic [NCDB*RW-1:0] cdb_rob_id;
  logic [NCDB*32-1:0] cdb_data;
  logic rob_en, reg_en, rs_en, ls_en, rob_is_jump, rob_is_store, rob_pred_jump;
  logic [31:0] rob_pc, rob_rollback_pc, disp_V1, disp_V2, disp_pc, disp_imm;
  logic [7:0]  disp_opnum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dispatch_queue #(.IQ_DEPTH(DEPTH), .NUM_CDB(NCDB), .ROB_ID_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .fch_valid(fch_valid), .fch_inst(fch_inst), .fch_pc(fch_pc),
    .fch_pred_jump(fch_pred_jump), .fch_rollback_pc(fch_rollback_pc),
    .fch_ready(fch_ready), .rollback(rollback),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .V1_from_rob(V1_from_rob), .V2_from_rob(V2_from_rob),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_id_from_rob(rob_id_from_rob),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .rob_en(rob_en), .reg_en(reg_en), .rs_en(rs_en), .ls_en(ls_en),
    .rob_rd(rob_rd), .reg_rd(reg_rd),
    .rob_is_jump(rob_is_jump), .rob_is_store(rob_is_store), .rob_pred_jump(rob_pred_jump),
    .rob_pc(rob_pc), .rob_rollback_pc(rob_rollback_pc),
    .reg_rob_id(reg_rob_id), .disp_rob_id(disp_rob_id),
    .disp_opnum(disp_opnum), .disp_V1(disp_V1), .disp_V2(disp_V2),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_Q1(disp_Q1), .disp_Q2(disp_Q2)
  );

  // Expected-value record for one queued instruction.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] rbpc;
    logic [7:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        is_ls;
    logic        is_null;
  } ent_t;

  typedef struct {
    logic [31:0] inst;
    logic        rob_full, rs_full, lsb_full;
    logic [3:0]  exp_en;
    logic [7:0]  exp_op;
    logic [31:0] exp_imm;
  } vec_t;

  ent_t model_q[$];
  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    rdy = 1'b1; fch_valid = 1'b0; fch_inst = '0; fch_pc = '0;
    fch_pred_jump = 1'b0; fch_rollback_pc = '0; rollback = 1'b0;
    Q1_from_reg = '0; Q2_from_reg = '0; V1_from_reg = '0; V2_from_reg = '0;
    Q1_ready_from_rob = 1'b0; Q2_ready_from_rob = 1'b0;
    V1_from_rob = '0; V2_from_rob = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_id_from_rob = 4'd5;
    cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0;
  endtask

  task automatic clearQueue();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
  endtask

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] b, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] j, input logic [4:0] rd);
    return {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
  endfunction

  // Operand forwarding rule: first matching valid CDB channel, then ROB, then regfile.
  function automatic logic [35:0] resolve(input logic [RW-1:0] q, input logic [31:0] v,
                                          input logic rr, input logic [31:0] vr);
    for (int i = 0; i < NCDB; i++) begin
      if (cdb_valid[i] && q != 0 && cdb_rob_id[i*RW +: RW] == q)
        return {4'h0, cdb_data[i*32 +: 32]};
    end
    if (rr) return {4'h0, vr};
    return {q, v};
  endfunction

  task automatic genInst(output ent_t e);
    int kind;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm12;
    logic [12:0] b;
    logic        alt;
    kind  = $urandom_range(0, 5);
    rd    = 5'($urandom);
    rs1   = 5'($urandom);
    rs2   = 5'($urandom);
    imm12 = 12'($urandom);
    alt   = 1'($urandom);
    b     = {imm12, 1'b0};
    e.rd = rd; e.is_ls = 1'b0; e.is_null = 1'b0;
    e.imm = {{20{imm12[11]}}, imm12};
    case (kind)
      0: begin e.inst = encI(imm12, rs1, 3'b000, rd, 7'b0010011); e.op = 8'h80; end
      1: begin e.inst = encI(imm12, rs1, 3'b010, rd, 7'b0000011); e.op = 8'h64; e.is_ls = 1'b1; end
      2: begin e.inst = encS(imm12, rs2, rs1, 3'b010); e.op = 8'h74; e.is_ls = 1'b1; e.rd = 5'd0; end
      3: begin
        e.inst = {alt ? 7'b0100000 : 7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
        e.op = alt ? 8'h91 : 8'h90; e.imm = 32'd0;
      end
      4: begin e.inst = encB(b, rs2, rs1); e.op = 8'h50; e.rd = 5'd0; e.imm = {{19{b[12]}}, b}; end
      default: begin e.inst = 32'h0; e.op = 8'h00; e.is_null = 1'b1; e.imm = 32'd0; e.rd = 5'd0; end
    endcase
    e.pc   = $urandom;
    e.pred = 1'($urandom);
    e.rbpc = $urandom;
  endtask

  initial begin
    logic [35:0] op1, op2;
    applyStimulus();

    #2;
    checkOutput("reset_state", {rob_en, reg_en, rs_en, ls_en, fch_ready}, 5'b0);
    rst_n = 1'b1;
    step();
    checkOutput("ready_after_reset", fch_ready, 1'b1);

    vecs[0]  = '{encI(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 0, 4'b1110, 8'h80, 32'd5};
    vecs[1]  = '{encI(-12'sd3, 5'd1, 3'b000, 5'd2, 7'b0010011), 0, 1, 0, 4'b0000, 8'h80, 32'hFFFFFFFD};
    vecs[2]  = '{encI(12'd8, 5'd2, 3'b010, 5'd3, 7'b0000011), 0, 0, 1, 4'b0000, 8'h64, 32'd8};
    vecs[3]  = '{encI(-12'sd4, 5'd2, 3'b010, 5'd3, 7'b0000011), 0, 1, 0, 4'b1101, 8'h64, 32'hFFFFFFFC};
    vecs[4]  = '{encS(12'd12, 5'd5, 5'd6, 3'b010), 1, 0, 0, 4'b0000, 8'h74, 32'd12};
    vecs[5]  = '{encS(-12'sd16, 5'd5, 5'd6, 3'b010), 0, 0, 0, 4'b1101, 8'h74, 32'hFFFFFFF0};
    vecs[6]  = '{encB(13'd16, 5'd2, 5'd1), 0, 0, 1, 4'b1110, 8'h50, 32'd16};
    vecs[7]  = '{{7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}, 0, 0, 0, 4'b1110, 8'h91, 32'd0};
    vecs[8]  = '{{20'h12345, 5'd4, 7'b0110111}, 0, 0, 0, 4'b1110, 8'h10, 32'h12345000};
    vecs[9]  = '{32'h0, 0, 0, 0, 4'b0000, 8'h00, 32'd0};
    vecs[10] = '{encJ(21'd8, 5'd1), 0, 0, 0, 4'b1110, 8'h30, 32'd8};

    for (int k = 0; k < 11; k++) begin
      applyStimulus();
      rob_full = vecs[k].rob_full; rs_full = vecs[k].rs_full; lsb_full = vecs[k].lsb_full;
      fch_valid = 1'b1; fch_inst = vecs[k].inst; fch_pc = 32'h1000 + 32'(k*4);
      step();
      fch_valid = 1'b0;
      #1;
      checkOutput($sformatf("vec%0d_en", k), {rob_en, reg_en, rs_en, ls_en}, vecs[k].exp_en);
      checkOutput($sformatf("vec%0d_op", k), disp_opnum, vecs[k].exp_op);
      checkOutput($sformatf("vec%0d_imm", k), disp_imm, vecs[k].exp_imm);
      if (k == 0) checkOutput("vec0_operand1", {disp_Q1, disp_V1}, 36'h0);
      clearQueue();
    end

    // Fill to capacity behind a full RS, then drain in order.
    applyStimulus();
    rs_full = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      fch_valid = 1'b1;
      fch_inst  = encI(12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011);
      step();
    end
    fch_inst = encI(12'd99, 5'd0, 3'b000, 5'd1, 7'b0010011);
    #1;
    checkOutput("full_ready", fch_ready, 1'b0);
    step();
    fch_valid = 1'b0;
    rs_full   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      checkOutput($sformatf("drain%0d", k), {rob_en, rs_en, disp_imm}, {2'b11, 32'(k)});
      step();
    end
    #1;
    checkOutput("drained_empty", rob_en, 1'b0);

    // CDB priority and fallbacks on operand 1.
    applyStimulus();
    rs_full = 1'b1; fch_valid = 1'b1;
    fch_inst = encI(12'd1, 5'd3, 3'b000, 5'd1, 7'b0010011);
    step();
    fch_valid = 1'b0;
    Q1_from_reg = 4'd3; V1_from_reg = 32'd55;
    cdb_valid = 2'b11; cdb_rob_id = {4'd3, 4'd3}; cdb_data = {32'd9, 32'd7};
    #1;
    checkOutput("cdb_both", {disp_Q1, disp_V1}, {4'd0, 32'd7});
    cdb_valid = 2'b10;
    #1;
    checkOutput("cdb_ch1", {disp_Q1, disp_V1}, {4'd0, 32'd9});
    cdb_valid = 2'b00; Q1_ready_from_rob = 1'b1; V1_from_rob = 32'd66;
    #1;
    checkOutput("rob_ready", {disp_Q1, disp_V1}, {4'd0, 32'd66});
    Q1_ready_from_rob = 1'b0;
    #1;
    checkOutput("reg_pending", {disp_Q1, disp_V1}, {4'd3, 32'd55});
    clearQueue();

    // Rollback with five queued entries; the push in the same cycle is lost.
    applyStimulus();
    rs_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      fch_valid = 1'b1; fch_inst = encI(12'(k + 20), 5'd0, 3'b000, 5'd1, 7'b0010011);
      step();
    end
    rs_full = 1'b0; rollback = 1'b1;
    fch_inst = encI(12'd77, 5'd0, 3'b000, 5'd1, 7'b0010011);
    #1;
    checkOutput("rollback_cycle", {fch_ready, rob_en, rs_en}, 3'b000);
    step();
    rollback = 1'b0; fch_valid = 1'b0;
    #1;
    checkOutput("after_rollback", {fch_ready, rob_en}, 2'b10);
    fch_valid = 1'b1; fch_inst = encI(12'd42, 5'd0, 3'b000, 5'd1, 7'b0010011);
    step();
    fch_valid = 1'b0;
    #1;
    checkOutput("post_rollback_disp", {rob_en, disp_imm}, {1'b1, 32'd42});
    step();

    // Asynchronous reset in the middle of a dispatch.
    applyStimulus();
    rs_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fch_valid = 1'b1; fch_inst = encI(12'(k + 1), 5'd0, 3'b000, 5'd1, 7'b0010011);
      step();
    end
    fch_valid = 1'b0; rs_full = 1'b0;
    #1;
    checkOutput("pre_reset_fire", rob_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {rob_en, reg_en, rs_en, ls_en, fch_ready}, 5'b0);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("reset_release", {rob_en, fch_ready}, 2'b01);
    step();
    checkOutput("reset_empty", rob_en, 1'b0);

    // Randomized traffic against the queue model.
    model_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ent_t e, h;
      logic exp_ready, live, blocked, fire;
      genInst(e);
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      rob_full = ($urandom_range(0, 5) == 0);
      rs_full = ($urandom_range(0, 3) == 0);
      lsb_full = ($urandom_range(0, 3) == 0);
      fch_valid = ($urandom_range(0, 2) != 0);
      fch_inst = e.inst; fch_pc = e.pc; fch_pred_jump = e.pred; fch_rollback_pc = e.rbpc;
      Q1_from_reg = 4'($urandom_range(0, 3)); Q2_from_reg = 4'($urandom_range(0, 3));
      V1_from_reg = $urandom; V2_from_reg = $urandom;
      V1_from_rob = $urandom; V2_from_rob = $urandom;
      Q1_ready_from_rob = ($urandom_range(0, 3) == 0);
      Q2_ready_from_rob = ($urandom_range(0, 3) == 0);
      cdb_valid = 2'($urandom);
      cdb_rob_id = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      cdb_data = {$urandom, $urandom};
      #1;
      exp_ready = !rollback && (model_q.size() < DEPTH);
      live = rdy && (model_q.size() != 0) && !rollback;
      h = '{default: '0};
      if (model_q.size() != 0) h = model_q[0];
      blocked = rob_full || (h.is_ls ? lsb_full : rs_full);
      fire = live && !h.is_null && !blocked;
      checkOutput("rand_strobes", {fch_ready, rob_en, reg_en, rs_en, ls_en},
                  {exp_ready, fire, fire, fire && !h.is_ls, fire && h.is_ls});
      if (fire) begin
        op1 = resolve(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, V1_from_rob);
        op2 = resolve(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, V2_from_rob);
        checkOutput("rand_payload",
          {disp_opnum, disp_imm, disp_pc, rob_rd, rob_pred_jump, rob_rollback_pc,
           disp_Q1, disp_V1, disp_Q2, disp_V2},
          {h.op, h.imm, h.pc, h.rd, h.pred, h.rbpc, op1, op2});
      end
      if (rollback) begin
        if (rdy) model_q.delete();
      end else begin
        if (live && (fire || h.is_null)) void'(model_q.pop_front());
        if (fch_valid && exp_ready && rdy) model_q.push_back(e);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
